// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IFU/LSU requesters, the memory bridge and mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) ();
  logic              flush;

  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req_valid;
  logic              ls_req_ready;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_wen;
  logic [DATA_W-1:0] ls_wdata;
  logic [3:0]        ls_wlen;
  logic              ls_resp_valid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wlen;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  flush,
    input  if_req_valid, if_addr,
    output if_req_ready, if_resp_valid, if_rdata,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wlen,
    output ls_req_ready, ls_resp_valid, ls_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wlen,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output busy
  );

  modport master (
    output flush,
    output if_req_valid, if_addr,
    input  if_req_ready, if_resp_valid, if_rdata,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wlen,
    input  ls_req_ready, ls_resp_valid, ls_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wlen,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// LSU has fixed priority; a starvation counter hands the IFU a contended grant after STARVE_MAX losses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rstn,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned    CntW      = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q;
  logic              owner_if_q;
  logic              drop_q;
  logic [CntW-1:0]   starve_q;
  logic              busy_q;

  logic              mem_req_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wen_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [3:0]        mem_wlen_q;

  logic              if_resp_valid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              ls_resp_valid_q;
  logic [DATA_W-1:0] ls_rdata_q;

  logic idle, starved, if_win, ls_win, if_fire, ls_fire, drop_now;

  always_comb begin
    idle     = (state_q == StIdle);
    starved  = (starve_q == StarveMax);
    // IFU takes a contended slot only once starved; a flush blocks any new fetch.
    if_win   = bus.if_req_valid && !bus.flush && (!bus.ls_req_valid || starved);
    ls_win   = bus.ls_req_valid && !if_win;
    if_fire  = idle && if_win;
    ls_fire  = idle && ls_win;
    drop_now = drop_q || (owner_if_q && bus.flush);
  end

  assign bus.if_req_ready  = if_fire;
  assign bus.ls_req_ready  = ls_fire;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wlen      = mem_wlen_q;
  assign bus.if_resp_valid = if_resp_valid_q;
  assign bus.if_rdata      = if_rdata_q;
  assign bus.ls_resp_valid = ls_resp_valid_q;
  assign bus.ls_rdata      = ls_rdata_q;
  assign bus.busy          = busy_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= StIdle;
      owner_if_q      <= 1'b0;
      drop_q          <= 1'b0;
      starve_q        <= '0;
      busy_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= '0;
      mem_wlen_q      <= '0;
      if_resp_valid_q <= 1'b0;
      if_rdata_q      <= '0;
      ls_resp_valid_q <= 1'b0;
      ls_rdata_q      <= '0;
    end else begin
      if_resp_valid_q <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_fire || ls_fire) begin
            state_q         <= StReq;
            busy_q          <= 1'b1;
            mem_req_valid_q <= 1'b1;
            owner_if_q      <= if_fire;
            if (if_fire) begin
              mem_addr_q  <= bus.if_addr;
              mem_wen_q   <= 1'b0;
              mem_wdata_q <= '0;
              mem_wlen_q  <= '0;
              starve_q    <= '0;
            end else begin
              mem_addr_q  <= bus.ls_addr;
              mem_wen_q   <= bus.ls_wen;
              mem_wdata_q <= bus.ls_wdata;
              mem_wlen_q  <= bus.ls_wlen;
              if (bus.if_req_valid && !starved) begin
                starve_q <= starve_q + 1'b1;
              end
            end
          end
        end
        StReq: begin
          if (owner_if_q && bus.flush) begin
            drop_q <= 1'b1;
          end
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= StWait;
          end
        end
        StWait: begin
          if (bus.mem_resp_valid) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            if (!owner_if_q) begin
              ls_resp_valid_q <= 1'b1;
              ls_rdata_q      <= mem_wen_q ? '0 : bus.mem_rdata;
            end else if (!drop_now) begin
              // A flushed fetch still drains the memory but never reaches the IFU.
              if_resp_valid_q <= 1'b1;
              if_rdata_q      <= bus.mem_rdata;
            end
          end else if (owner_if_q && bus.flush) begin
            drop_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants,
// memory requests and responses; negedge monitors compare what the DUT presents.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 64;
  localparam int unsigned DW   = 64;
  localparam int unsigned SMAX = 4;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [3:0]  wlen;
  } req_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  req_t        req_q[$];
  logic [63:0] if_q[$];
  logic [63:0] ls_q[$];
  logic [63:0] mem[logic [63:0]];

  // Transaction-level model of the port.
  bit   m_busy, m_wait, m_owner_if, m_drop;
  int   m_loss, m_delay;
  req_t m_cur;
  int   p_if, p_ls, p_flush, p_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[31:0] ^ 32'h0010_0073, ~a[31:0]};
  endfunction

  task automatic drive_idle();
    bus.flush = 1'b0;
    bus.if_req_valid = 1'b0; bus.if_addr = '0;
    bus.ls_req_valid = 1'b0; bus.ls_addr = '0; bus.ls_wen = 1'b0;
    bus.ls_wdata = '0; bus.ls_wlen = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_owner_if = 0; m_drop = 0; m_loss = 0; m_delay = 0;
    req_q.delete(); if_q.delete(); ls_q.delete();
  endtask

  task automatic cycle();
    bit ifv, lsv, fl, rdy, rv, exp_ifr, exp_lsr;
    logic [63:0] rdata, ifa;
    req_t lr;
    @(negedge clk);
    ifv = ($urandom_range(99) < p_if);
    lsv = ($urandom_range(99) < p_ls);
    fl  = ($urandom_range(99) < p_flush);
    rdy = ($urandom_range(99) < p_rdy);
    ifa = 64'h8000_0000 + 64'(($urandom_range(15)) << 3);
    lr.addr  = 64'h8000_1000 + 64'(($urandom_range(15)) << 3);
    lr.wen   = $urandom_range(1) == 1;
    lr.wdata = {$urandom, $urandom};
    lr.wlen  = 4'(1 << $urandom_range(3));
    rv = 1'b0;
    rdata = {$urandom, $urandom};
    if (m_busy && m_wait) begin
      if (m_delay == 0) begin
        rv = 1'b1;
        rdata = mem_rd(m_cur.addr);
      end else begin
        m_delay--;
      end
    end else if ($urandom_range(99) < 5) begin
      rv = 1'b1;  // stray response the DUT must ignore
    end
    bus.flush = fl;
    bus.if_req_valid = ifv; bus.if_addr = ifa;
    bus.ls_req_valid = lsv; bus.ls_addr = lr.addr; bus.ls_wen = lr.wen;
    bus.ls_wdata = lr.wdata; bus.ls_wlen = lr.wlen;
    bus.mem_req_ready = rdy; bus.mem_resp_valid = rv; bus.mem_rdata = rdata;
    #1;
    exp_ifr = !m_busy && ifv && !fl && (!lsv || m_loss == int'(SMAX));
    exp_lsr = !m_busy && lsv && !exp_ifr;
    chk("if_req_ready", 64'(bus.if_req_ready), 64'(exp_ifr));
    chk("ls_req_ready", 64'(bus.ls_req_ready), 64'(exp_lsr));
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(m_busy && !m_wait));
    @(posedge clk);
    if (m_busy && m_owner_if && fl) m_drop = 1;
    if (m_busy && m_wait && rv) begin
      m_busy = 0; m_wait = 0;
      if (m_owner_if) begin
        if (!m_drop) if_q.push_back(rdata);
      end else begin
        ls_q.push_back(m_cur.wen ? 64'd0 : rdata);
      end
    end else if (m_busy && !m_wait && rdy) begin
      m_wait = 1;
      m_delay = $urandom_range(2);
      if (m_cur.wen) mem[m_cur.addr] = m_cur.wdata;
      void'(req_q.pop_front());
    end
    if (exp_ifr || exp_lsr) begin
      if (exp_ifr) begin
        m_cur.addr = ifa; m_cur.wen = 0; m_cur.wdata = '0; m_cur.wlen = '0;
        m_loss = 0;
      end else begin
        m_cur = lr;
        if (ifv && m_loss < int'(SMAX)) m_loss++;
      end
      req_q.push_back(m_cur);
      m_busy = 1; m_wait = 0; m_drop = 0; m_owner_if = exp_ifr;
    end
  endtask

  task automatic run_phase(input int pi, input int pl, input int pf, input int pr, input int n);
    p_if = pi; p_ls = pl; p_flush = pf; p_rdy = pr;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic reset_mid_wait();
    int k = 0;
    p_if = 100; p_ls = 0; p_flush = 0; p_rdy = 100;
    while (!(m_busy && m_wait) && k < 50) begin
      cycle();
      k++;
    end
    chk("reach_wait", 64'(m_busy && m_wait), 64'd1);
    @(negedge clk);
    mon_en = 1'b0;
    rstn = 1'b0;
    drive_idle();
    @(posedge clk);
    model_reset();
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_if_resp", 64'(bus.if_resp_valid), 64'd0);
    chk("rst_ls_resp", 64'(bus.ls_resp_valid), 64'd0);
    rstn = 1'b1;
    mon_en = 1'b1;
  endtask

  // Scoreboard monitor: mem request fields and responses, sampled away from the clock edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_req_valid) begin
        if (req_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL mem_req: unexpected request addr %h, none expected", bus.mem_addr);
        end else begin
          chk("mem_addr", bus.mem_addr, req_q[0].addr);
          chk("mem_wen", 64'(bus.mem_wen), 64'(req_q[0].wen));
          chk("mem_wdata", bus.mem_wdata, req_q[0].wdata);
          chk("mem_wlen", 64'(bus.mem_wlen), 64'(req_q[0].wlen));
        end
      end
      if (bus.if_resp_valid) begin
        if (if_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL if_resp: pulse with rdata %h, none expected", bus.if_rdata);
        end else begin
          chk("if_rdata", bus.if_rdata, if_q.pop_front());
        end
      end else if (if_q.size() != 0) begin
        n_cmp++; n_err++;
        $display("FAIL if_resp: missing pulse, got 0 expected 1 (data %h)", if_q.pop_front());
      end
      if (bus.ls_resp_valid) begin
        if (ls_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL ls_resp: pulse with rdata %h, none expected", bus.ls_rdata);
        end else begin
          chk("ls_rdata", bus.ls_rdata, ls_q.pop_front());
        end
      end else if (ls_q.size() != 0) begin
        n_cmp++; n_err++;
        $display("FAIL ls_resp: missing pulse, got 0 expected 1 (data %h)", ls_q.pop_front());
      end
    end
  end

  initial begin
    drive_idle();
    model_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("reset_mem_addr", bus.mem_addr, 64'd0);
    chk("reset_mem_wen", 64'(bus.mem_wen), 64'd0);
    chk("reset_mem_wdata", bus.mem_wdata, 64'd0);
    chk("reset_mem_wlen", 64'(bus.mem_wlen), 64'd0);
    chk("reset_if_resp_valid", 64'(bus.if_resp_valid), 64'd0);
    chk("reset_ls_resp_valid", 64'(bus.ls_resp_valid), 64'd0);
    chk("reset_if_rdata", bus.if_rdata, 64'd0);
    chk("reset_ls_rdata", bus.ls_rdata, 64'd0);
    rstn = 1'b1;
    mon_en = 1'b1;

    run_phase(100, 0, 0, 100, 30);     // fetch only, fast memory
    run_phase(100, 100, 0, 100, 150);  // full contention: starvation guard
    run_phase(0, 100, 0, 25, 100);     // loads/stores with a slow accept
    run_phase(100, 0, 30, 100, 100);   // fetches under frequent flush
    run_phase(60, 60, 10, 60, 600);    // mixed traffic
    reset_mid_wait();
    run_phase(50, 50, 10, 70, 250);
    run_phase(0, 0, 0, 100, 20);       // drain

    chk("drain_queues", 64'(req_q.size() + if_q.size() + ls_q.size()), 64'd0);
    chk("drain_busy", 64'(bus.busy), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
